// File: rtl/cache_refill_ctrl.sv
// Miss engine below the D-cache: dirty-victim writeback, then line refill.
// Optional CRITICAL_WORD_FIRST_EN starts the refill at the missed word.
module cache_refill_ctrl #(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int IDXW           = $clog2(WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic                  victim_dirty,
  input  logic [ADDR_WIDTH-1:0] victim_addr,
  output logic [IDXW-1:0]       victim_idx,
  input  logic [WIDTH-1:0]      victim_data,
  output logic                  fill_we,
  output logic [IDXW-1:0]       fill_idx,
  output logic [WIDTH-1:0]      fill_data,
  output logic                  miss_done,
  output logic                  busy,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [WIDTH-1:0]      mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [WIDTH-1:0]      mem_rsp_data
);

  localparam int OFFW = IDXW + 2;
  localparam int TAGW = ADDR_WIDTH - OFFW;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS_PER_LINE - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WB_REQ    = 3'd1;
  localparam logic [2:0] S_FILL_REQ  = 3'd2;
  localparam logic [2:0] S_FILL_WAIT = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]      state;
  logic [TAGW-1:0] fill_tag;
  logic [TAGW-1:0] wb_tag;
  logic [IDXW-1:0] cnt;
  logic [IDXW-1:0] first_idx;
  logic            fill_last;
  logic            unused;

  assign unused = ^{miss_addr[OFFW-1:0], victim_addr[OFFW-1:0]};

`ifdef CRITICAL_WORD_FIRST_EN
  logic [IDXW-1:0] start_idx;
  logic [IDXW-1:0] xfer;
  assign first_idx = miss_addr[IDXW+1:2];
  // Wrapped order means the index alone cannot mark the end of the line.
  assign fill_last = (xfer == LAST);
`else
  assign first_idx = '0;
  assign fill_last = (cnt == LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fill_tag <= '0;
      wb_tag   <= '0;
      cnt      <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      start_idx <= '0;
      xfer      <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (miss_valid) begin
            fill_tag <= miss_addr[ADDR_WIDTH-1:OFFW];
            wb_tag   <= victim_addr[ADDR_WIDTH-1:OFFW];
            cnt      <= victim_dirty ? '0 : first_idx;
`ifdef CRITICAL_WORD_FIRST_EN
            start_idx <= first_idx;
            xfer      <= '0;
`endif
            state <= victim_dirty ? S_WB_REQ : S_FILL_REQ;
          end
        end
        S_WB_REQ: begin
          if (mem_req_ready) begin
            if (cnt == LAST) begin
`ifdef CRITICAL_WORD_FIRST_EN
              cnt <= start_idx;
`else
              cnt <= '0;
`endif
              state <= S_FILL_REQ;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_FILL_REQ: begin
          if (mem_req_ready) state <= S_FILL_WAIT;
        end
        S_FILL_WAIT: begin
          if (mem_rsp_valid) begin
            if (fill_last) begin
              state <= S_DONE;
            end else begin
              cnt   <= cnt + 1'b1;
`ifdef CRITICAL_WORD_FIRST_EN
              xfer  <= xfer + 1'b1;
`endif
              state <= S_FILL_REQ;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    victim_idx    = '0;
    fill_we       = 1'b0;
    fill_idx      = '0;
    fill_data     = '0;
    miss_done     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    unique case (state)
      S_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        victim_idx    = cnt;
        mem_req_addr  = {wb_tag, cnt, 2'b00};
        mem_req_wdata = victim_data;
      end
      S_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {fill_tag, cnt, 2'b00};
      end
      S_FILL_WAIT: begin
        fill_we   = mem_rsp_valid;
        fill_idx  = cnt;
        fill_data = mem_rsp_data;
      end
      S_DONE:  miss_done = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a small memory model.
// Build with +define+CRITICAL_WORD_FIRST_EN to check wrapped refill order.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        victim_dirty;
  logic [31:0] victim_addr;
  logic [1:0]  victim_idx;
  logic [31:0] victim_data;
  logic        fill_we;
  logic [1:0]  fill_idx;
  logic [31:0] fill_data;
  logic        miss_done;
  logic        busy;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .victim_idx(victim_idx), .victim_data(victim_data),
    .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
    .miss_done(miss_done), .busy(busy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          stall = 0;
  int          wait_cnt = 0;
  logic        spur = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;
  logic        held_v = 1'b0;
  logic [65:0] held = '0;
  int          stab_err = 0;

  logic [31:0] req_addr [0:255];
  logic        req_we   [0:255];
  logic [31:0] req_wd   [0:255];
  int          n_req = 0;
  logic [1:0]  fl_idx   [0:255];
  logic [31:0] fl_data  [0:255];
  int          n_fill = 0;

  assign victim_data   = 32'h100 + {30'd0, victim_idx};
  assign mem_req_ready = (wait_cnt >= stall);
  assign mem_rsp_valid = pend | spur;
  assign mem_rsp_data  = pend ? pend_data : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pend     <= 1'b0;
      wait_cnt <= 0;
      held_v   <= 1'b0;
    end else begin
      pend <= 1'b0;
      if (mem_req_valid && mem_req_ready) begin
        wait_cnt       <= 0;
        req_addr[n_req] <= mem_req_addr;
        req_we[n_req]   <= mem_req_we;
        req_wd[n_req]   <= mem_req_wdata;
        n_req          <= n_req + 1;
        if (!mem_req_we) begin
          pend      <= 1'b1;
          pend_data <= mem_req_addr ^ 32'hA5A5_A5A5;
        end
      end else if (mem_req_valid) begin
        wait_cnt <= wait_cnt + 1;
      end
      if (fill_we) begin
        fl_idx[n_fill]  <= fill_idx;
        fl_data[n_fill] <= fill_data;
        n_fill          <= n_fill + 1;
      end
      if (held_v && ({mem_req_valid, mem_req_we, mem_req_addr,
                      mem_req_wdata} != held))
        stab_err <= stab_err + 1;
      held_v <= mem_req_valid && !mem_req_ready;
      held   <= {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata};
    end
  end

  int tests = 0;
  int fails = 0;
  int t0 = 0;
  int rb = 0;
  int fb = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int first_word(input logic [31:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
    return int'(a[3:2]);
`else
    return 0;
`endif
  endfunction

  task automatic start_miss(input logic [31:0] a, input logic d,
                            input logic [31:0] va);
    @(negedge clk);
    miss_valid   = 1'b1;
    miss_addr    = a;
    victim_dirty = d;
    victim_addr  = va;
    t0 = cyc;
    rb = n_req;
    fb = n_fill;
  endtask

  task automatic wait_done(input string tag, input int exp);
    int dt;
    dt = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (miss_done) begin
        dt = cyc - t0;
        miss_valid = 1'b0;
        break;
      end
    end
    chk(tag, dt, exp);
    @(negedge clk);
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] vb);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_wb_addr"}, req_addr[rb+k], vb + 32'(4*k));
      chk({tag, "_wb_we"}, {31'd0, req_we[rb+k]}, 32'd1);
      chk({tag, "_wb_data"}, req_wd[rb+k], 32'h100 + 32'(k));
    end
  endtask

  task automatic chk_fill(input string tag, input logic [31:0] lb,
                          input int st, input int off);
    int idx;
    logic [31:0] a;
    for (int k = 0; k < 4; k++) begin
      idx = (st + k) % 4;
      a   = lb + 32'(4*idx);
      chk({tag, "_rd_addr"}, req_addr[rb+off+k], a);
      chk({tag, "_rd_we"}, {31'd0, req_we[rb+off+k]}, 32'd0);
      chk({tag, "_fill_idx"}, {30'd0, fl_idx[fb+k]}, 32'(idx));
      chk({tag, "_fill_data"}, fl_data[fb+k], a ^ 32'hA5A5_A5A5);
    end
    chk({tag, "_fill_count"}, 32'(n_fill - fb), 32'd4);
  endtask

  initial begin
    bit found;
    rst          = 1'b1;
    miss_valid   = 1'b0;
    miss_addr    = '0;
    victim_dirty = 1'b0;
    victim_addr  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, miss_done}, 32'd0);
    chk("rst_fill_we", {31'd0, fill_we}, 32'd0);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_req_we", {31'd0, mem_req_we}, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_vidx", {30'd0, victim_idx}, 32'd0);
    chk("rst_fidx", {30'd0, fill_idx}, 32'd0);
    rst = 1'b0;

    // clean miss
    start_miss(32'h0000_1234, 1'b0, 32'h0000_9000);
    wait_done("clean_lat", 9);
    chk_fill("clean", 32'h0000_1230, first_word(32'h0000_1234), 0);

    // dirty miss
    start_miss(32'h0000_0040, 1'b1, 32'h0000_8000);
    wait_done("dirty_lat", 13);
    chk_wb("dirty", 32'h0000_8000);
    chk_fill("dirty", 32'h0000_0040, first_word(32'h0000_0040), 4);

    // backpressure: 3 stall cycles on each of 8 requests
    stall = 3;
    start_miss(32'h0000_0048, 1'b1, 32'h0000_8000);
    wait_done("bp_lat", 13 + 8*3);
    stall = 0;
    chk_wb("bp", 32'h0000_8000);
    chk_fill("bp", 32'h0000_0040, first_word(32'h0000_0048), 4);
    chk("bp_stable", 32'(stab_err), 32'd0);

    // reset while waiting on refill word 1
    start_miss(32'h0000_2000, 1'b0, 32'h0000_9000);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy && !mem_req_valid && !miss_done && fill_idx == 2'd1) begin
        rst = 1'b1;
        miss_valid = 1'b0;
        found = 1'b1;
        break;
      end
    end
    chk("rst_mid_found", {31'd0, found}, 32'd1);
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mid_fill_we", {31'd0, fill_we}, 32'd0);
    rst = 1'b0;
    start_miss(32'h0000_3008, 1'b0, 32'h0000_9000);
    wait_done("after_rst_lat", 9);
    chk_fill("after_rst", 32'h0000_3000, first_word(32'h0000_3008), 0);

    // stray responses in IDLE and WB_REQ
    @(negedge clk);
    spur = 1'b1;
    chk("spur_idle_fill_we", {31'd0, fill_we}, 32'd0);
    @(negedge clk);
    spur = 1'b0;
    chk("spur_idle_busy", {31'd0, busy}, 32'd0);
    start_miss(32'h0000_0040, 1'b1, 32'h0000_8000);
    @(negedge clk);
    spur = 1'b1;
    chk("spur_wb_we", {31'd0, mem_req_we}, 32'd1);
    chk("spur_wb_fill_we", {31'd0, fill_we}, 32'd0);
    @(negedge clk);
    spur = 1'b0;
    chk("spur_wb_addr", mem_req_addr, 32'h0000_8004);
    wait_done("spur_lat", 13);
    chk_wb("spur", 32'h0000_8000);
    chk_fill("spur", 32'h0000_0040, first_word(32'h0000_0040), 4);

    // miss on the last word of the line
    start_miss(32'h0000_123C, 1'b0, 32'h0000_9000);
    wait_done("cwf_lat", 9);
    chk_fill("cwf", 32'h0000_1230, first_word(32'h0000_123C), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss-handling engine sitting directly below the MEM-stage direct-mapped data cache, between the cache arrays and backing main memory. On a cache miss it writes back the victim line if the line is dirty, then refills the line word-by-word over a valid/ready memory interface. While it works it holds `busy`, which the hazard logic uses to stall the pipeline. It pulses `miss_done` when the line is installed.

Parameters:
- WIDTH, 32, data word width in bits.
- ADDR_WIDTH, 32, byte address width.
- WORDS_PER_LINE, 4, words per cache line; power of 2, at least 2.
- IDXW, $clog2(WORDS_PER_LINE), word-index width (derived, do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- miss_valid  in  1  cache miss request; held high until `miss_done`.
- miss_addr  in  ADDR_WIDTH  byte address of the missing access.
- victim_dirty  in  1  line being replaced holds modified data.
- victim_addr  in  ADDR_WIDTH  line-aligned byte address of the victim line.
- victim_idx  out  IDXW  word index of the victim line to read.
- victim_data  in  WIDTH  victim word at `victim_idx`; combinational from the cache.
- fill_we  out  1  write one refill word into the cache line.
- fill_idx  out  IDXW  word index for the refill write.
- fill_data  out  WIDTH  refill write data.
- miss_done  out  1  one-cycle pulse: line installed; cache sets tag/valid and clears dirty.
- busy  out  1  controller active; pipeline stall request.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_we  out  1  1 = write, 0 = read.
- mem_req_addr  out  ADDR_WIDTH  word-aligned byte address.
- mem_req_wdata  out  WIDTH  write data.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  WIDTH  read data.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset response: state goes to IDLE. `busy`, `miss_done`, `fill_we`, `mem_req_valid` and `mem_req_we` = 0. Indices and address/data outputs = 0.
- Reset mid-operation: the controller aborts to IDLE and drops any in-flight response. Memory is reset by the same `rst`.
- State machine: IDLE, WB_REQ, FILL_REQ, FILL_WAIT, DONE.
- IDLE:
  - When `miss_valid` = 1, register the line base. Line base = `miss_addr` with the low log2(WORDS_PER_LINE*4) bits cleared.
  - Also register `victim_addr` and `victim_dirty`, and reset the word counter.
  - Next state: WB_REQ if dirty, else FILL_REQ.
- WB_REQ:
  - `mem_req_valid` = 1, `mem_req_we` = 1, `victim_idx` = counter.
  - `mem_req_addr` = victim base + 4*counter; `mem_req_wdata` = `victim_data`.
  - On `mem_req_ready`: counter increments. After the last word, counter is reset to 0 and the state goes to FILL_REQ.
  - Writes get no response.
- FILL_REQ:
  - `mem_req_valid` = 1, `mem_req_we` = 0, `mem_req_addr` = fill base + 4*index.
  - On `mem_req_ready`, go to FILL_WAIT.
- FILL_WAIT:
  - One outstanding read only. The response arrives no earlier than the cycle after the request handshake.
  - `fill_we` = `mem_rsp_valid`; `fill_idx` = current index; `fill_data` = `mem_rsp_data` (combinational).
  - On `mem_rsp_valid`: if this was the last word, go to DONE; otherwise increment the index and return to FILL_REQ.
- DONE: `miss_done` = 1 for one cycle, then IDLE.
- Request stability: while `mem_req_valid` && !`mem_req_ready`, all `mem_req_*` outputs hold stable.
- Stray responses: `mem_rsp_valid` outside FILL_WAIT is ignored.
- `busy` = (state != IDLE).
- Miss after DONE: `miss_valid` still high in IDLE the cycle after `miss_done` is treated as a new miss. The cache must deassert it.
- Latency (`mem_req_ready` tied 1, response one cycle after the handshake, miss sampled at cycle 0, WORDS_PER_LINE = 4):
  - Clean miss: `miss_done` at cycle 1 + 2*WORDS_PER_LINE = 9.
  - Dirty miss: add WORDS_PER_LINE cycles, so `miss_done` at cycle 13.
- Arithmetic: the counter wraps modulo WORDS_PER_LINE. Address arithmetic is modulo 2^ADDR_WIDTH. The miss line base is never mixed with the victim base.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- When defined:
  - The refill starts at the missed word index, `miss_addr`[IDXW+1:2], and wraps modulo WORDS_PER_LINE.
  - Example, W = 4, miss at word 2: order is 2, 3, 0, 1.
  - The end of the refill is detected by a separate transfer count, not by index == last.
  - Writeback order is unchanged: index 0 upward.
- When undefined: the refill always runs index 0 to WORDS_PER_LINE-1.

Test Plan:
1. Clean miss: `miss_addr` = 0x0000_1234, dirty = 0, ready = 1, memory returns addr^0xA5A5A5A5.
   - Read addresses 0x1230, 0x1234, 0x1238, 0x123C.
   - `fill_we` data matches, `miss_done` at cycle 9, `busy` low at cycle 10.
2. Dirty miss: victim 0x0000_8000, `victim_data` = 0x100+idx, new line 0x40.
   - Four writes to 0x8000–0x800C with data 0x100–0x103, then four reads from 0x40–0x4C.
   - `miss_done` at cycle 13.
3. Backpressure: `mem_req_ready` low for 3 cycles on each request.
   - `mem_req_addr`/`mem_req_we`/`mem_req_wdata` held stable while stalled; completion delayed by exactly 3 cycles per request.
4. Reset mid-refill: assert `rst` in FILL_WAIT on word 1.
   - Next cycle: `busy` = 0, `mem_req_valid` = 0, `fill_we` = 0.
   - A fresh miss then completes normally.
5. Spurious response: pulse `mem_rsp_valid` in IDLE and WB_REQ.
   - No `fill_we`, no state change.
6. With CRITICAL_WORD_FIRST_EN: miss 0x0000_123C.
   - Reads in order 0x123C, 0x1230, 0x1234, 0x1238; `fill_idx` order 3, 0, 1, 2; `miss_done` still at cycle 9.
